// File: rtl/tristate_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tristate_arb_pkg
// Purpose  : Shared types and helpers for the tri-state bus arbiter: FSM state
//            encoding, counter/index width helpers and a one-hot encoder.
// Revision : 1.0 - initial release
// ============================================================================
package tristate_arb_pkg;

    // Widest supported requester count; the one-hot helper is sized for it.
    localparam int c_MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [c_MAX_REQ-1:0] onehot(input logic [3:0] idx);
        logic [c_MAX_REQ-1:0] v_vec;
        v_vec      = '0;
        v_vec[idx] = 1'b1;
        return v_vec;
    endfunction

endpackage : tristate_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : Combinational round-robin search. Scans req starting at last+1
//            (mod N_REQ) and reports the first requester found.
// Ports    : req    - request vector
//            last   - index of the most recent grantee
//            winner - selected requester index (0 when none found)
//            found  - high when any req bit is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import tristate_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_width(N_REQ)-1:0] last,
    output logic [idx_width(N_REQ)-1:0] winner,
    output logic                        found
);

    localparam int c_IDX_W = idx_width(N_REQ);

    logic [c_IDX_W-1:0] w_idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // after last is the final (winning) assignment. Offset N_REQ wraps back
    // onto last itself, so a lone requester is still re-granted.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        w_idx  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_idx = c_IDX_W'((int'(last) + i) % N_REQ);
            if (req[w_idx]) begin
                winner = w_idx;
                found  = 1'b1;
            end
        end
    end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tristate_bus_arbiter
// Purpose  : Round-robin output-enable generator for N_REQ tri-state drivers
//            sharing one bus. At most one enable is high at a time, each
//            grant is limited to MAX_HOLD cycles, and TURN_CYCLES all-off
//            cycles separate consecutive grants.
// Ports    : clk   - rising-edge clock
//            rst   - asynchronous active-high reset
//            req   - level-sensitive request per driver
//            oe    - one-hot-or-zero enables (bit i -> buffer i enable)
//            owner - current grantee index, valid while busy
//            busy  - OR of oe
//            turn  - high during bus-turnaround cycles
//            contention_err - sticky error flag (optional, see below)
// Config   : TRISTATE_ARB_CONTENTION_CHECK_EN - when defined, adds the
//            contention_err output and a simulation assertion.
// Revision : 1.0 - initial release
// ============================================================================
module tristate_bus_arbiter
    import tristate_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    output logic [N_REQ-1:0]            oe,
    output logic [idx_width(N_REQ)-1:0] owner,
    output logic                        busy,
`ifdef TRISTATE_ARB_CONTENTION_CHECK_EN
    output logic                        turn,
    output logic                        contention_err
`else
    output logic                        turn
`endif
);

    localparam int c_IDX_W  = idx_width(N_REQ);
    localparam int c_HOLD_W = cnt_width(MAX_HOLD);
    localparam int c_TURN_W = cnt_width(TURN_CYCLES);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT  = c_HOLD_W'(MAX_HOLD);
    localparam logic [c_TURN_W-1:0] c_TURN_LAST = c_TURN_W'(TURN_CYCLES - 1);

    arb_state_t          r_state;
    logic [N_REQ-1:0]    r_oe;
    logic [c_IDX_W-1:0]  r_owner;
    logic                r_busy;
    logic                r_turn;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_TURN_W-1:0] r_turn_cnt;
    logic [c_IDX_W-1:0]  r_last;

    logic [c_IDX_W-1:0]  w_winner;
    logic                w_found;
    logic [N_REQ-1:0]    w_grant_oe;
    logic                w_owner_req;
    logic                w_release;

    rr_priority_picker #(
        .N_REQ  (N_REQ)
    ) u_picker (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .found  (w_found)
    );

    assign w_grant_oe  = N_REQ'(onehot(4'(w_winner)));
    // r_oe is the one-hot of the owner while granting, so this is req[owner]
    // without a variable index.
    assign w_owner_req = |(req & r_oe);
    assign w_release   = !w_owner_req || (r_hold >= c_HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_oe       <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_turn     <= 1'b0;
            r_hold     <= '0;
            r_turn_cnt <= '0;
            r_last     <= c_IDX_W'(N_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_oe    <= w_grant_oe;
                        r_owner <= w_winner;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                    end
                end

                GRANT: begin
                    if (r_hold != c_HOLD_SAT) begin
                        r_hold <= r_hold + 1'b1;
                    end
                    if (w_release) begin
                        r_state    <= TURN;
                        r_oe       <= '0;
                        r_busy     <= 1'b0;
                        r_turn     <= 1'b1;
                        r_turn_cnt <= '0;
                        r_last     <= r_owner;
                    end
                end

                TURN: begin
                    if (r_turn_cnt == c_TURN_LAST) begin
                        r_turn <= 1'b0;
                        if (w_found) begin
                            r_state <= GRANT;
                            r_oe    <= w_grant_oe;
                            r_owner <= w_winner;
                            r_busy  <= 1'b1;
                            r_hold  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_oe    <= '0;
                    r_busy  <= 1'b0;
                    r_turn  <= 1'b0;
                end
            endcase
        end
    end

    assign oe    = r_oe;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign turn  = r_turn;

`ifdef TRISTATE_ARB_CONTENTION_CHECK_EN
    logic w_contention;
    logic r_contention_err;

    assign w_contention = ($countones(r_oe) > 1) || ((|r_oe) && r_turn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_contention_err <= 1'b0;
        end else if (w_contention) begin
            r_contention_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!w_contention);
        end
    end

    assign contention_err = r_contention_err;
`endif

endmodule : tristate_bus_arbiter
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tristate_bus_arbiter
// Purpose  : Directed scoreboard bench for tristate_bus_arbiter (N_REQ=4,
//            MAX_HOLD=4, TURN_CYCLES=2). Each stimulus cycle queues the
//            hand-derived outputs expected after the following clock edge;
//            a monitor pops and compares one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tristate_bus_arbiter;

    localparam int c_HOLD = 4;
    localparam int c_TURN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
    logic       turn;
`ifdef TRISTATE_ARB_CONTENTION_CHECK_EN
    logic       contention_err;
`endif

    tristate_bus_arbiter #(
        .N_REQ       (4),
        .MAX_HOLD    (c_HOLD),
        .TURN_CYCLES (c_TURN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .oe             (oe),
        .owner          (owner),
        .busy           (busy),
`ifdef TRISTATE_ARB_CONTENTION_CHECK_EN
        .turn           (turn),
        .contention_err (contention_err)
`else
        .turn           (turn)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] oe;
        logic [1:0] owner;
        logic       turn;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else    $display("FAIL %s: %s", name, detail);
    endtask

    // Drive req before the next edge and queue the outputs expected after it.
    task automatic step(input logic [3:0] r, input logic [3:0] e_oe,
                        input logic [1:0] e_owner, input logic e_turn, input string tag);
        exp_t e;
        @(negedge clk);
        req       = r;
        e.oe      = e_oe;
        e.owner   = e_owner;
        e.turn    = e_turn;
        e.tag     = tag;
        q.push_back(e);
    endtask

    task automatic g(input logic [3:0] r, input int idx, input int n, input string tag);
        repeat (n) step(r, 4'(1 << idx), 2'(idx), 1'b0, tag);
    endtask

    task automatic t(input logic [3:0] r, input string tag);
        repeat (c_TURN) step(r, 4'b0000, 2'd0, 1'b1, tag);
    endtask

    // Monitor: invariants every cycle plus one scoreboard entry when queued.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                check("onehot", $countones(oe) <= 1, $sformatf("oe=%b has more than one bit set", oe));
                check("busy_or", busy == (|oe), $sformatf("busy=%b but oe=%b", busy, oe));
`ifdef TRISTATE_ARB_CONTENTION_CHECK_EN
                check("contention", contention_err == 1'b0, $sformatf("contention_err=%b, required 0", contention_err));
`endif
                if (q.size() > 0) begin
                    e  = q.pop_front();
                    ok = (oe == e.oe) && (turn == e.turn) && (busy == (|e.oe)) &&
                         (!(|e.oe) || (owner == e.owner));
                    check(e.tag, ok, $sformatf("got oe=%b owner=%0d busy=%b turn=%b, required oe=%b owner=%0d busy=%b turn=%b",
                          oe, owner, busy, turn, e.oe, e.owner, |e.oe, e.turn));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_state", (oe == 4'b0000) && (owner == 2'd0) && !busy && !turn,
              $sformatf("oe=%b owner=%0d busy=%b turn=%b, required all zero", oe, owner, busy, turn));
        rst = 1'b0;

        // Requester 0 after reset: one-cycle latency, release, turnaround, idle.
        g(4'b0001, 0, 2, "req0_grant");
        t(4'b0000, "req0_turn");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "req0_idle");

        // Lone requester 1 held: hold limit, turnaround, re-grant.
        g(4'b0010, 1, c_HOLD, "hold1_first");
        t(4'b0010, "hold1_turn");
        g(4'b0010, 1, c_HOLD, "hold1_again");
        t(4'b0000, "hold1_end");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "hold1_idle");

        // All requesting: rotation continues from last=1.
        g(4'b1111, 2, c_HOLD, "rot_2");
        t(4'b1111, "rot_t2");
        g(4'b1111, 3, c_HOLD, "rot_3");
        t(4'b1111, "rot_t3");
        g(4'b1111, 0, c_HOLD, "rot_0");
        t(4'b1111, "rot_t0");
        g(4'b1111, 1, c_HOLD, "rot_1");
        t(4'b1111, "rot_t1");
        g(4'b1111, 2, c_HOLD, "rot_2b");
        t(4'b0000, "rot_end");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "rot_idle");

        // 0101 from last=2: requester 0 first, drops, then requester 2.
        g(4'b0101, 0, 3, "mix_0");
        t(4'b0100, "mix_turn");
        g(4'b0100, 2, 2, "mix_2");
        t(4'b0000, "mix_end");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "mix_idle");

        // Asynchronous reset in the middle of a grant.
        g(4'b0011, 0, 2, "pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", (oe == 4'b0000) && !busy && !turn,
              $sformatf("oe=%b busy=%b turn=%b, required all zero", oe, busy, turn));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;

        // After reset requester 0 has first priority over 3.
        g(4'b1001, 0, 2, "post_rst_0");
        t(4'b1000, "post_rst_turn");
        g(4'b1000, 3, 2, "post_rst_3");
        t(4'b0000, "post_rst_end");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "post_rst_idle");

        repeat (3) @(negedge clk);
        check("drain", q.size() == 0, $sformatf("%0d entries left, required 0", q.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tristate_bus_arbiter
`default_nettype wire
